// File: rtl/aes_key_expand_ctrl_pkg.sv
// Shared constants, state encoding and S-box/Rcon helpers for the AES-128
// key-expansion sequencer, plus the FIPS-197 A.1 reference schedule.
package aes_key_expand_ctrl_pkg;

    localparam int AES_NR = 10;
    localparam int AES_KW = 128;
    localparam int RIDX_W = 4;

    typedef logic [RIDX_W-1:0] ridx_t;
    typedef logic [AES_KW-1:0] key_t;

    localparam ridx_t LAST_RIDX = ridx_t'(AES_NR);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // FIPS-197 Appendix A.1 cipher key and its complete round-key schedule.
    localparam key_t FIPS_A1_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam key_t FIPS_A1_RK [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // Round constant for rounds 1..10. Round 0 has no defined Rcon; the
    // sequencer never selects it, so it simply returns zero.
    function automatic logic [7:0] rcon(input ridx_t round);
        logic [7:0] r;
        case (round)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes_key_expand_ctrl_round_key_gen.sv
// Single AES-128 key-schedule round: derives round key N from round key N-1.
// Purely combinational; bit 127 is the first (most significant) key bit.
module aes_key_expand_ctrl_round_key_gen
    import aes_key_expand_ctrl_pkg::*;
(
    input  logic [AES_KW-1:0] key_in,
    input  ridx_t             round,
    output logic [AES_KW-1:0] key_out
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot_w, sub_w, temp_w;
    logic [31:0] n0, n1, n2, n3;

    // RotWord, SubWord and Rcon on the last word, then the XOR ripple.
    always_comb begin
        w0      = key_in[127:96];
        w1      = key_in[95:64];
        w2      = key_in[63:32];
        w3      = key_in[31:0];
        rot_w   = {w3[23:0], w3[31:24]};
        sub_w   = {sbox(rot_w[31:24]), sbox(rot_w[23:16]),
                   sbox(rot_w[15:8]),  sbox(rot_w[7:0])};
        temp_w  = sub_w ^ {rcon(round), 24'h000000};
        n0      = w0 ^ temp_w;
        n1      = w1 ^ n0;
        n2      = w2 ^ n1;
        n3      = w3 ^ n2;
        key_out = {n0, n1, n2, n3};
    end

endmodule

// File: rtl/aes_key_expand_ctrl.sv
// AES-128 key-expansion sequencer: accepts a cipher key, runs one round per
// clock through the round-key generator, stores all 11 round keys and serves
// them through a registered read port.
module aes_key_expand_ctrl
    import aes_key_expand_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              key_valid,
    output logic              key_ready,
    input  logic [AES_KW-1:0] key_in,
    output logic              busy,
    output logic              keys_valid,
    input  ridx_t             rk_rd_idx,
    output logic [AES_KW-1:0] rk_rd_data,
    output logic              rk_rd_valid
);

    state_e            state_q, state_d;
    ridx_t             cnt_q, cnt_d;
    logic [AES_KW-1:0] rk_rd_data_q, rk_rd_data_d;
    logic              rk_rd_valid_q, rk_rd_valid_d;

    logic [AES_KW-1:0] rk_q [0:10];

    logic              accept;
    logic              rk_we;
    ridx_t             rk_waddr;
    logic [AES_KW-1:0] rk_wdata;
    ridx_t             rkg_sel;
    ridx_t             rkg_round;
    logic [AES_KW-1:0] rkg_next;
    logic              rd_in_range;

    assign key_ready   = (state_q != ST_EXPAND);
    assign busy        = (state_q == ST_EXPAND);
    assign keys_valid  = (state_q == ST_DONE);
    assign rk_rd_data  = rk_rd_data_q;
    assign rk_rd_valid = rk_rd_valid_q;
    assign accept      = key_valid && key_ready;

    // Generator input: previous round key and the current round number.
    // Outside EXPAND the round input is held at 1 so Rcon(0) is never used.
    always_comb begin
        rkg_sel   = (cnt_q == '0) ? '0 : cnt_q - ridx_t'(1);
        rkg_round = (state_q == ST_EXPAND) ? cnt_q : ridx_t'(1);
    end

    aes_key_expand_ctrl_round_key_gen u_round_key_gen (
        .key_in  (rk_q[rkg_sel]),
        .round   (rkg_round),
        .key_out (rkg_next)
    );

    // Next-state, round counter and register-file write selection.
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rk_we    = 1'b0;
        rk_waddr = '0;
        rk_wdata = '0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_d  = ST_EXPAND;
                    cnt_d    = ridx_t'(1);
                    rk_we    = 1'b1;
                    rk_waddr = '0;
                    rk_wdata = key_in;
                end
            end
            ST_EXPAND: begin
                rk_we    = 1'b1;
                rk_waddr = cnt_q;
                rk_wdata = rkg_next;
                if (cnt_q == LAST_RIDX) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ridx_t'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Read port: valid only for indices 0..10 while the current key set is
    // complete; the accept edge still sees the old set as valid.
    always_comb begin
        rd_in_range   = (rk_rd_idx <= LAST_RIDX);
        rk_rd_data_d  = rd_in_range ? rk_q[rk_rd_idx] : '0;
        rk_rd_valid_d = keys_valid && rd_in_range;
    end

    // Control and read-port registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            rk_rd_data_q  <= '0;
            rk_rd_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rk_rd_data_q  <= rk_rd_data_d;
            rk_rd_valid_q <= rk_rd_valid_d;
        end
    end

    // Round-key register file.
    // NOTE: deliberately not reset; contents are only trusted once
    // keys_valid is set, so a reset would only add fan-out.
    always_ff @(posedge clk) begin
        if (rk_we) begin
            rk_q[rk_waddr] <= rk_wdata;
        end
    end

endmodule

// File: tb/tb_aes_key_expand_ctrl.sv
// Scoreboard bench for aes_key_expand_ctrl: reads push expected results into
// a queue, a monitor pops and compares when the read result is due.
module tb_aes_key_expand_ctrl;
    import aes_key_expand_ctrl_pkg::*;

    localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    typedef struct {
        logic [3:0]   idx;
        logic         vld;
        logic [127:0] data;
        bit           chk_data;
    } rd_exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] key_in;
    logic         busy;
    logic         keys_valid;
    logic [3:0]   rk_rd_idx;
    logic [127:0] rk_rd_data;
    logic         rk_rd_valid;

    logic         rd_req = 1'b0;
    rd_exp_t      exp_q[$];
    int           n_checks = 0;
    int           n_pass = 0;

    always #5 clk = ~clk;

    aes_key_expand_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .key_in      (key_in),
        .busy        (busy),
        .keys_valid  (keys_valid),
        .rk_rd_idx   (rk_rd_idx),
        .rk_rd_data  (rk_rd_data),
        .rk_rd_valid (rk_rd_valid)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Drive one read for the coming edge and record what it must return.
    task automatic issue_rd(input logic [3:0] idx, input logic vld,
                            input logic [127:0] data, input bit chk_data);
        rd_exp_t e;
        e.idx = idx; e.vld = vld; e.data = data; e.chk_data = chk_data;
        rk_rd_idx = idx;
        rd_req    = 1'b1;
        exp_q.push_back(e);
    endtask

    // Read monitor: a request driven before an edge is due 1 time unit after it.
    initial begin
        rd_exp_t e;
        forever begin
            @(posedge clk);
            if (rd_req) begin
                #1;
                if (exp_q.size() == 0) begin
                    check("rd_unexpected", 128'd1, 128'd0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("rd_valid[%0d]", e.idx), {127'd0, rk_rd_valid}, {127'd0, e.vld});
                    if (e.chk_data)
                        check($sformatf("rd_data[%0d]", e.idx), rk_rd_data, e.data);
                end
            end
        end
    end

    // Offer a key from IDLE/DONE and wait for keys_valid. With hold set,
    // key_valid stays high and key_in keeps changing during the expansion.
    task automatic load_key(input string tag, input logic [127:0] k, input bit hold);
        int n;
        int ready_lo;
        key_in    = k;
        key_valid = 1'b1;
        @(negedge clk);
        n        = 1;
        ready_lo = key_ready ? 0 : 1;
        check({tag, "_busy"}, {127'd0, busy}, 128'd1);
        check({tag, "_kv_drop"}, {127'd0, keys_valid}, 128'd0);
        if (!hold) key_valid = 1'b0;
        while (!keys_valid && n < 30) begin
            if (hold) key_in = key_in + 128'h1111_0000_0000_0000_0000_0000_0000_0001;
            @(negedge clk);
            n++;
            if (!key_ready) ready_lo++;
        end
        key_valid = 1'b0;
        check({tag, "_latency"}, 128'(n), 128'd11);
        check({tag, "_ready_lo"}, 128'(ready_lo), 128'd10);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        key_valid = 1'b0;
        key_in    = '0;
        rk_rd_idx = '0;
        repeat (2) @(negedge clk);
        check("rst_key_ready", {127'd0, key_ready}, 128'd1);
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_keys_valid", {127'd0, keys_valid}, 128'd0);
        check("rst_rd_valid", {127'd0, rk_rd_valid}, 128'd0);
        check("rst_rd_data", rk_rd_data, 128'd0);
        rst = 1'b0;
        @(negedge clk);

        // FIPS-197 A.1 schedule, then every index back-to-back and the range edges.
        load_key("a1", FIPS_A1_KEY, 1'b0);
        for (int i = 0; i <= 10; i++) begin
            issue_rd(4'(i), 1'b1, FIPS_A1_RK[i], 1'b1);
            @(negedge clk);
        end
        issue_rd(4'd11, 1'b0, 128'd0, 1'b1);
        @(negedge clk);
        issue_rd(4'd15, 1'b0, 128'd0, 1'b1);
        @(negedge clk);
        rd_req = 1'b0;

        // Read on the same edge as a new accept: old data valid, then invalid.
        key_in    = '0;
        key_valid = 1'b1;
        issue_rd(4'd3, 1'b1, FIPS_A1_RK[3], 1'b1);
        @(negedge clk);
        key_valid = 1'b0;
        issue_rd(4'd3, 1'b0, 128'd0, 1'b0);
        @(negedge clk);
        rd_req = 1'b0;
        begin
            int n = 2;
            while (!keys_valid && n < 30) begin
                @(negedge clk);
                n++;
            end
            check("zero1_latency", 128'(n), 128'd11);
        end
        issue_rd(4'd0, 1'b1, 128'd0, 1'b1);
        @(negedge clk);
        issue_rd(4'd1, 1'b1, ZERO_RK1, 1'b1);
        @(negedge clk);
        issue_rd(4'd10, 1'b1, ZERO_RK10, 1'b1);
        @(negedge clk);
        rd_req = 1'b0;

        // key_valid held through EXPAND with changing key_in: first key wins.
        load_key("hold", FIPS_A1_KEY, 1'b1);
        issue_rd(4'd1, 1'b1, FIPS_A1_RK[1], 1'b1);
        @(negedge clk);
        issue_rd(4'd10, 1'b1, FIPS_A1_RK[10], 1'b1);
        @(negedge clk);
        rd_req = 1'b0;

        // Zero key loaded from DONE.
        load_key("zero2", 128'd0, 1'b0);
        issue_rd(4'd1, 1'b1, ZERO_RK1, 1'b1);
        @(negedge clk);
        issue_rd(4'd10, 1'b1, ZERO_RK10, 1'b1);
        @(negedge clk);
        rd_req = 1'b0;

        // Reset in the middle of an A.1 expansion (cnt=5), then a clean zero load.
        rk_rd_idx = 4'd0;
        key_in    = FIPS_A1_KEY;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_busy", {127'd0, busy}, 128'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_key_ready", {127'd0, key_ready}, 128'd1);
        check("mid_rst_busy", {127'd0, busy}, 128'd0);
        check("mid_rst_keys_valid", {127'd0, keys_valid}, 128'd0);
        check("mid_rst_rd_valid", {127'd0, rk_rd_valid}, 128'd0);
        check("mid_rst_rd_data", rk_rd_data, 128'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_keys_valid", {127'd0, keys_valid}, 128'd0);
        load_key("zero3", 128'd0, 1'b0);
        for (int i = 0; i <= 10; i += 5) begin
            issue_rd(4'(i), 1'b1, (i == 0) ? 128'd0 : FIPS_A1_RK[i], 1'b0);
            @(negedge clk);
        end
        rd_req = 1'b0;
        issue_rd(4'd1, 1'b1, ZERO_RK1, 1'b1);
        @(negedge clk);
        issue_rd(4'd10, 1'b1, ZERO_RK10, 1'b1);
        @(negedge clk);
        issue_rd(4'd0, 1'b1, 128'd0, 1'b1);
        @(negedge clk);
        rd_req = 1'b0;

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
